// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridge.
//  - default AXI IDs for instruction and data traffic
//  - constant AXI field values
//  - read and write FSM state encodings
//  - write-strobe helper for little-endian sub-word stores
package sram_axi_bridge_pkg;

  localparam logic [3:0] INST_ID_DEF    = 4'd0;
  localparam logic [3:0] DATA_ID_DEF    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } w_state_e;

  // Byte lanes touched by a store of 2**size bytes at the given low address bits.
  function automatic logic [3:0] wstrb_for(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 4'b0001 << addr_lo;
      2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: joins the CPU's instruction and data SRAM-like ports
// (req / addr_ok / data_ok) onto a single AXI3 master.
//  clk, resetn          clock, asynchronous active-low reset
//  inst_* / data_*      CPU-side request ports; addr_ok accepts, data_ok completes
//  ar* / r*             AXI read address / read data channels
//  aw* / w* / b*        AXI write address / write data / write response channels
// One read and one write may be outstanding, single-beat only. Data reads have
// priority over instruction fetches; reads are held off while a pending write
// targets the same word.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  r_state_e    r_state_q;
  logic [3:0]  ar_id_q;
  logic [31:0] ar_addr_q;
  logic [1:0]  ar_size_q;
  logic        arvalid_q;

  w_state_e    w_state_q;
  logic [31:0] aw_addr_q;
  logic [1:0]  aw_size_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        awvalid_q;
  logic        wvalid_q;

  logic w_busy, data_rd_req, data_hazard, inst_hazard;
  logic r_idle, data_rd_acc, inst_rd_acc, data_wr_acc;
  logic r_done, r_to_data, b_done, aw_done, w_done;

  // Responses are never errored back to the CPU; instruction writes do not exist.
  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_wdata, rresp, rlast, bid, bresp};

  // ---------------- arbitration and hazard ----------------
  assign w_busy      = (w_state_q != W_IDLE);
  assign data_rd_req = data_req & ~data_wr;
  // Word-granular RAW check against the single pending write.
  assign data_hazard = w_busy & (aw_addr_q[31:2] == data_addr[31:2]);
  assign inst_hazard = w_busy & (aw_addr_q[31:2] == inst_addr[31:2]);

  // Acceptance is gated by resetn so no addr_ok escapes while reset is held.
  assign r_idle      = resetn & (r_state_q == R_IDLE);
  // A pending data read owns the read slot even when hazard-stalled, so
  // fetches never overtake an older load.
  assign data_rd_acc = r_idle & data_rd_req & ~data_hazard;
  assign inst_rd_acc = r_idle & ~data_rd_req & inst_req & ~inst_hazard;
  assign data_wr_acc = resetn & (w_state_q == W_IDLE) & data_req & data_wr;

  assign inst_addr_ok = inst_rd_acc;
  assign data_addr_ok = data_rd_acc | data_wr_acc;

  // ---------------- completions ----------------
  assign rready    = (r_state_q == R_R);
  assign r_done    = rready & rvalid;
  assign r_to_data = (rid == DATA_ID);
  // A data read finishing this cycle owns data_data_ok; the write response waits.
  assign bready    = (w_state_q == W_B) & ~(r_done & r_to_data);
  assign b_done    = bready & bvalid;

  assign inst_data_ok = r_done & ~r_to_data;
  assign data_data_ok = (r_done & r_to_data) | b_done;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // ---------------- read FSM ----------------
  // NOTE: state uses non-blocking assignments and resets asynchronously; the
  // latched request fields are reset too so AXI outputs are never X after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      arvalid_q <= 1'b0;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_size_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (data_rd_acc || inst_rd_acc) begin
            ar_id_q   <= data_rd_acc ? DATA_ID : INST_ID;
            ar_addr_q <= data_rd_acc ? data_addr : inst_addr;
            ar_size_q <= data_rd_acc ? data_size : inst_size;
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            r_state_q <= R_R;
          end
        end
        R_R: begin
          if (rvalid) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  assign aw_done = ~awvalid_q | awready;
  assign w_done  = ~wvalid_q | wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (data_wr_acc) begin
            aw_addr_q <= data_addr;
            aw_size_q <= data_size;
            w_data_q  <= data_wdata;
            w_strb_q  <= wstrb_for(data_size, data_addr[1:0]);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state_q <= W_REQ;
          end
        end
        W_REQ: begin
          // AW and W complete independently, in either order or together.
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) w_state_q <= W_B;
        end
        W_B: begin
          if (b_done) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- AXI outputs ----------------
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;

  assign awid    = DATA_ID;
  assign awaddr  = aw_addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, aw_size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;

  assign wid     = DATA_ID;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

endmodule
